// File: rtl/itof_core.sv
// Signed 32-bit integer to IEEE-754 binary32 converter, round-to-nearest-even.
// Fully pipelined: one operand per cycle, result two edges after the sampling edge.
module itof_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] src,
    output logic        out_valid,
    output logic [31:0] dest
);

    // Valid-only streaming: in_valid qualifies src on the edge that samples it, and
    // out_valid qualifies dest; there is no ready, so every accepted operand emerges.

    function automatic logic [4:0] count_lz(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Stage 1: sign, magnitude and leading-zero count
    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic [4:0]  s1_lz;
    logic        s1_zero;

    logic [31:0] mag_d;
    always_comb begin
        mag_d = src[31] ? (~src + 32'd1) : src;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
        if (in_valid) begin
            s1_sign <= src[31];
            s1_mag  <= mag_d;
            s1_lz   <= count_lz(mag_d);
            s1_zero <= (mag_d == 32'd0);
        end
    end

    // Stage 2: normalise and extract fraction, guard and sticky
    logic        s2_valid;
    logic        s2_sign;
    logic        s2_zero;
    logic [7:0]  s2_exp;
    logic [22:0] s2_frac;
    logic        s2_guard;
    logic        s2_sticky;

    logic [31:0] norm;
    always_comb begin
        norm = s1_mag << s1_lz;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        if (s1_valid) begin
            s2_sign   <= s1_sign;
            s2_zero   <= s1_zero;
            s2_exp    <= 8'd158 - {3'b000, s1_lz};
            s2_frac   <= norm[30:8];
            s2_guard  <= norm[7];
            s2_sticky <= |norm[6:0];
        end
    end

    // Output stage: round to nearest even; a fraction carry bumps the exponent
    logic        round_up;
    logic [23:0] frac_sum;
    logic [7:0]  exp_rnd;
    logic [31:0] dest_d;

    always_comb begin
        round_up = s2_guard && (s2_sticky || s2_frac[0]);
        frac_sum = {1'b0, s2_frac} + {23'd0, round_up};
        exp_rnd  = s2_exp + {7'd0, frac_sum[23]};
        if (s2_zero) dest_d = 32'h0000_0000;
        else         dest_d = {s2_sign, exp_rnd, frac_sum[22:0]};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            dest      <= 32'h0000_0000;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) dest <= dest_d;
        end
    end

endmodule

// File: tb/tb_itof_core.sv
// Self-checking bench for itof_core: directed values, negative sweep, rounding
// corners, randomized stream with gaps, and reset with operands in flight.
module tb_itof_core;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic [31:0] src;
    logic        out_valid;
    logic [31:0] dest;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] last_dest = 32'h0;

    itof_core dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .src       (src),
        .out_valid (out_valid),
        .dest      (dest)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact magnitude, find exponent, round remainder with integer arithmetic
    function automatic logic [31:0] itof_ref(input logic [31:0] s);
        logic [63:0] m, q, r, half;
        int          e, sh;
        logic        sg;
        if (s == 32'd0) return 32'h0;
        sg = s[31];
        m  = {32'd0, s};
        if (sg) m = 64'h1_0000_0000 - m;
        e = 0;
        while ((m >> (e + 1)) != 64'd0) e++;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            sh   = e - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {sg, 8'(e + 127), q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, sampled at the next rising edge
    task automatic drive_exp(input logic v, input logic [31:0] s, input logic [31:0] expv);
        @(negedge clk);
        rstn     = 1'b1;
        in_valid = v;
        src      = s;
        if (v) begin
            exp_q.push_back(expv);
            due_q.push_back(cyc + 3);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] s);
        drive_exp(v, s, itof_ref(s));
    endtask

    task automatic apply_reset(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            rstn     = 1'b0;
            in_valid = 1'b1;
            src      = $urandom;
            exp_q.delete();
            due_q.delete();
            last_dest = 32'h0;
        end
    endtask

    // Scoreboard monitor: checks timing, order and value one time unit after each edge
    always @(posedge clk) begin
        logic        exp_v;
        logic [31:0] e;
        cyc++;
        #1;
        exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        if (exp_v) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            check("dest", dest, e);
            last_dest = e;
        end else begin
            check("dest_hold", dest, last_dest);
        end
    end

    initial begin
        logic [31:0] r;
        rstn     = 1'b0;
        in_valid = 1'b1;
        src      = 32'h1234_5678;

        // Reset held with in_valid high
        apply_reset(3);

        // Basics, first operand straight after release
        drive_exp(1'b1, 32'h0000_0000, 32'h0000_0000);
        drive_exp(1'b1, 32'h0000_0001, 32'h3F80_0000);
        drive_exp(1'b1, 32'hFFFF_FFFF, 32'hBF80_0000);
        drive_exp(1'b1, 32'h8000_0000, 32'hCF00_0000);

        // Rounding corners
        drive_exp(1'b1, 32'd16777217, 32'h4B80_0000);
        drive_exp(1'b1, 32'd16777219, 32'h4B80_0002);
        drive_exp(1'b1, 32'h7FFF_FFFF, 32'h4F00_0000);
        drive_exp(1'b1, 32'hFF80_0000, 32'hCB00_0000);
        drive_exp(1'b1, 32'hC000_0000, 32'hCE80_0000);
        drive_exp(1'b1, 32'd16777216, 32'h4B80_0000);
        drive(1'b0, 32'h0);

        // Negative sweep
        for (int i = 0; i < 256; i++) begin
            r = {1'b1, 8'(i), 23'd0};
            drive(1'b1, r);
        end

        // Random stream with bubbles
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(0, 3) == 0) drive(1'b0, $urandom);
            case ($urandom_range(0, 3))
                0: r = $urandom;
                1: r = 32'($urandom_range(0, 1 << 25)) - 32'd16777216;
                2: r = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 3)) - 32'd1;
                default: r = {$urandom_range(0, 1) == 1, 31'($urandom)} | 32'h7F;
            endcase
            drive(1'b1, r);
        end

        // Reset with two operands in flight: neither may appear
        drive(1'b1, 32'd12345);
        drive(1'b1, 32'hFFFF_0000);
        apply_reset(2);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0);

        // Restart after the mid-flight reset
        drive(1'b1, 32'd7);
        drive(1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0);

        @(negedge clk);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
